// File: rtl/hilo_mult_ctrl.sv
// HI/LO register owner and sequencer for the shared iterative multiplier.
// Signed MULT is issued as an unsigned magnitude multiply and the product sign is fixed on capture.
module hilo_mult_ctrl #(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        busy,
    output logic        error,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_valid_in,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_valid_out,
    input  logic [63:0] mul_r
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       mul_a_q, mul_a_d;
    logic [31:0]       mul_b_q, mul_b_d;
    logic              mul_valid_in_q, mul_valid_in_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              error_q, error_d;

    logic              op_legal;
    logic              op_req;
    logic              accepted;
    logic [31:0]       abs_rs;
    logic [31:0]       abs_rt;
    logic [63:0]       product;

    // 000 and 111 are both "no operation" for this block.
    assign op_legal = (op != 3'b000) && (op != 3'b111);
    assign op_req   = op_valid && op_legal;
    assign accepted = op_req && (state_q == ST_IDLE);

    assign abs_rs  = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
    assign abs_rt  = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
    assign product = neg_q ? (~mul_r + 64'd1) : mul_r;

    always_comb begin
        state_d        = state_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        mul_valid_in_d = 1'b0;
        neg_d          = neg_q;
        cnt_d          = cnt_q;
        error_d        = error_q;

        case (state_q)
            ST_IDLE: begin
                if (accepted) begin
                    case (op)
                        OP_MULT: begin
                            mul_a_d        = abs_rs;
                            mul_b_d        = abs_rt;
                            neg_d          = rs_data[31] ^ rt_data[31];
                            mul_valid_in_d = 1'b1;
                            state_d        = ST_ISSUE;
                        end
                        OP_MULTU: begin
                            mul_a_d        = rs_data;
                            mul_b_d        = rt_data;
                            neg_d          = 1'b0;
                            mul_valid_in_d = 1'b1;
                            state_d        = ST_ISSUE;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            ST_ISSUE: begin
                // mul_valid_in_q is high for exactly this cycle.
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (mul_valid_out) begin
                    {hi_d, lo_d} = product;
                    state_d      = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            hi_q           <= '0;
            lo_q           <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            mul_valid_in_q <= 1'b0;
            neg_q          <= 1'b0;
            cnt_q          <= '0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            mul_valid_in_q <= mul_valid_in_d;
            neg_q          <= neg_d;
            cnt_q          <= cnt_d;
            error_q        <= error_d;
        end
    end

    assign stall        = op_req && (state_q != ST_IDLE);
    assign busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign error        = error_q;
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign mul_valid_in = mul_valid_in_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;

    always_comb begin
        read_data = 32'd0;
        if (op == OP_MFHI) begin
            read_data = hi_q;
        end else if (op == OP_MFLO) begin
            read_data = lo_q;
        end
    end

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl: table of multiply vectors plus hand sequences
// for stalls, ignored results, timeout and reset during a multiply.
module tb_hilo_mult_ctrl;

    localparam int MAX_WAIT = 64;
    localparam int CNT_W    = 7;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b100;
    localparam logic [2:0] OP_MFHI  = 3'b101;
    localparam logic [2:0] OP_MFLO  = 3'b110;

    logic        clk;
    logic        reset_n;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic [31:0] read_data;
    logic        busy;
    logic        error;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mul_valid_in;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_valid_out;
    logic [63:0] mul_r;

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;

    hilo_mult_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .op_valid      (op_valid),
        .op            (op),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .stall         (stall),
        .read_data     (read_data),
        .busy          (busy),
        .error         (error),
        .hi            (hi),
        .lo            (lo),
        .mul_valid_in  (mul_valid_in),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_valid_out (mul_valid_out),
        .mul_r         (mul_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (mul_valid_in) pulse_cnt++;
    endtask

    // Present a multiply in IDLE and take the accept edge; leaves the DUT in ISSUE.
    task automatic start_mult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        pulse_cnt = 0;
        #1;
        check("stall_at_accept", 64'(stall), 64'd0);
        step();
        op_valid = 1'b0;
        op       = OP_NONE;
    endtask

    // In ISSUE: check the start pulse and operands, latch them as the stub multiplier would.
    task automatic issue_cycle(input logic [31:0] ea, input logic [31:0] eb,
                               output logic [63:0] prod);
        check("mul_valid_in_issue", 64'(mul_valid_in), 64'd1);
        check("busy_issue", 64'(busy), 64'd1);
        check("mul_a", 64'(mul_a), 64'(ea));
        check("mul_b", 64'(mul_b), 64'(eb));
        prod = 64'(mul_a) * 64'(mul_b);
        step();
    endtask

    // In WAIT: hold off for 'delay' cycles, then return the product for one cycle.
    task automatic respond(input int delay, input logic [63:0] prod);
        for (int k = 0; k < delay; k++) begin
            check("busy_wait", 64'(busy), 64'd1);
            check("mul_valid_in_wait", 64'(mul_valid_in), 64'd0);
            step();
        end
        mul_valid_out = 1'b1;
        mul_r         = prod;
        step();
        mul_valid_out = 1'b0;
        mul_r         = '0;
    endtask

    logic [63:0] prod;
    int          wait_cycles;

    initial begin
        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'h00000003, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{OP_MULT,  32'h00000007, 32'h00000006, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A};
        vecs[4] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFA, 32'h00000007, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[5] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[6] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h00000000, 32'h00000001};
        vecs[7] = '{OP_MULT,  32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};

        reset_n       = 1'b0;
        op_valid      = 1'b0;
        op            = OP_NONE;
        rs_data       = '0;
        rt_data       = '0;
        mul_valid_out = 1'b0;
        mul_r         = '0;

        // Reset values
        repeat (3) step();
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_mul_valid_in", 64'(mul_valid_in), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
        reset_n = 1'b1;
        step();

        op_valid = 1'b1;
        op = OP_MFHI;
        #1;
        check("rst_mfhi_data", 64'(read_data), 64'd0);
        check("rst_mfhi_stall", 64'(stall), 64'd0);
        op = OP_MFLO;
        #1;
        check("rst_mflo_data", 64'(read_data), 64'd0);
        check("rst_mflo_stall", 64'(stall), 64'd0);
        step();

        // MTHI / MTLO and read-back
        op = OP_MTHI; rs_data = 32'hAAAA0000;
        step();
        check("mthi_hi", 64'(hi), 64'h00000000AAAA0000);
        op = OP_MTLO; rs_data = 32'h00005555;
        step();
        check("mtlo_lo", 64'(lo), 64'h0000000000005555);
        check("mtlo_hi_kept", 64'(hi), 64'h00000000AAAA0000);
        op = OP_MFHI;
        #1;
        check("mfhi_data", 64'(read_data), 64'h00000000AAAA0000);
        op = OP_MFLO;
        #1;
        check("mflo_data", 64'(read_data), 64'h0000000000005555);
        op_valid = 1'b0;
        op = OP_NONE;
        step();

        // Table of multiplies
        for (int i = 0; i < 8; i++) begin
            start_mult(vecs[i].op, vecs[i].rs, vecs[i].rt);
            issue_cycle(vecs[i].exp_a, vecs[i].exp_b, prod);
            respond(i % 4, prod);
            check("busy_after_capture", 64'(busy), 64'd0);
            check("hi", 64'(hi), 64'(vecs[i].exp_hi));
            check("lo", 64'(lo), 64'(vecs[i].exp_lo));
            check("one_pulse", 64'(pulse_cnt), 64'd1);
        end

        // mul_valid_out in IDLE and ISSUE is ignored
        mul_valid_out = 1'b1; mul_r = 64'h0000DEAD0000BEEF;
        step();
        mul_valid_out = 1'b0; mul_r = '0;
        check("idle_resp_hi", 64'(hi), 64'd0);
        check("idle_resp_lo", 64'(lo), 64'd0);
        check("idle_resp_busy", 64'(busy), 64'd0);
        start_mult(OP_MULTU, 32'd3, 32'd3);
        mul_valid_out = 1'b1; mul_r = 64'h0000000000000BAD;
        issue_cycle(32'd3, 32'd3, prod);
        mul_valid_out = 1'b0; mul_r = '0;
        check("issue_resp_busy", 64'(busy), 64'd1);
        check("issue_resp_lo", 64'(lo), 64'd0);
        respond(2, prod);
        check("after_issue_resp_lo", 64'(lo), 64'd9);

        // MULT 7*6 with MFLO held behind it
        start_mult(OP_MULT, 32'd7, 32'd6);
        op_valid = 1'b1; op = OP_MFLO;
        #1;
        check("mflo_stall_issue", 64'(stall), 64'd1);
        issue_cycle(32'd7, 32'd6, prod);
        check("mflo_stall_wait", 64'(stall), 64'd1);
        step();
        check("mflo_stall_wait2", 64'(stall), 64'd1);
        mul_valid_out = 1'b1; mul_r = prod;
        #1;
        check("mflo_stall_capture", 64'(stall), 64'd1);
        step();
        mul_valid_out = 1'b0; mul_r = '0;
        check("mflo_stall_released", 64'(stall), 64'd0);
        check("mflo_new_product", 64'(read_data), 64'd42);
        step();
        op_valid = 1'b0; op = OP_NONE;

        // MTHI while busy stalls, then lands after the result
        start_mult(OP_MULTU, 32'd2, 32'd2);
        op_valid = 1'b1; op = OP_MTHI; rs_data = 32'h00001234;
        #1;
        check("mthi_stall_issue", 64'(stall), 64'd1);
        issue_cycle(32'd2, 32'd2, prod);
        check("mthi_stall_wait", 64'(stall), 64'd1);
        respond(1, prod);
        check("mthi_stall_released", 64'(stall), 64'd0);
        check("mthi_prod_lo", 64'(lo), 64'd4);
        check("mthi_prod_hi", 64'(hi), 64'd0);
        step();
        op_valid = 1'b0; op = OP_NONE;
        check("mthi_after_busy", 64'(hi), 64'h0000000000001234);
        check("mthi_lo_kept", 64'(lo), 64'd4);

        // Timeout: multiplier never answers
        op_valid = 1'b1;
        op = OP_MTHI; rs_data = 32'hCAFE0001;
        step();
        op = OP_MTLO; rs_data = 32'hBEEF0002;
        step();
        op_valid = 1'b0; op = OP_NONE;
        start_mult(OP_MULTU, 32'd9, 32'd9);
        issue_cycle(32'd9, 32'd9, prod);
        wait_cycles = 0;
        while (busy && wait_cycles < 200) begin
            if (wait_cycles == MAX_WAIT - 1) check("error_before_timeout", 64'(error), 64'd0);
            step();
            wait_cycles++;
        end
        check("timeout_wait_cycles", 64'(wait_cycles), 64'(MAX_WAIT));
        check("timeout_error", 64'(error), 64'd1);
        check("timeout_busy", 64'(busy), 64'd0);
        check("timeout_hi_kept", 64'(hi), 64'h00000000CAFE0001);
        check("timeout_lo_kept", 64'(lo), 64'h00000000BEEF0002);
        start_mult(OP_MULTU, 32'd2, 32'd3);
        issue_cycle(32'd2, 32'd3, prod);
        respond(3, prod);
        check("post_timeout_lo", 64'(lo), 64'd6);
        check("post_timeout_hi", 64'(hi), 64'd0);
        check("error_sticky", 64'(error), 64'd1);

        // Reset asserted while waiting
        start_mult(OP_MULTU, 32'd4, 32'd5);
        issue_cycle(32'd4, 32'd5, prod);
        step();
        reset_n = 1'b0;
        #1;
        check("rst_wait_busy", 64'(busy), 64'd0);
        check("rst_wait_hi", 64'(hi), 64'd0);
        check("rst_wait_lo", 64'(lo), 64'd0);
        check("rst_wait_error", 64'(error), 64'd0);
        step();
        reset_n = 1'b1;
        mul_valid_out = 1'b1; mul_r = 64'd5;
        step();
        mul_valid_out = 1'b0; mul_r = '0;
        check("late_resp_lo", 64'(lo), 64'd0);
        check("late_resp_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
